// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, adds them LSB-first
// through a single full_adder cell one bit per clock, and returns {c_out, sum} over valid/ready.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = (WIDTH > 1) ? WIDTH - 1 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [SH_W-1:0]  r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_out_valid;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_sum_next;
  logic [SH_W-1:0]  w_sum_sh_next;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .c_in (r_carry),
    .s    (w_fa_s),
    .c_out(w_fa_c)
  );

  // The partial-sum shifter only holds bits already produced, so it is one bit
  // narrower than the result; the single-bit case needs no shifter at all.
  if (WIDTH == 1) begin : g_w1
    assign w_sum_next    = w_fa_s;
    assign w_sum_sh_next = '0;
  end else begin : g_wn
    assign w_sum_next    = {w_fa_s, r_sum_sh};
    assign w_sum_sh_next = w_sum_next[WIDTH-1:1];
  end

  // NOTE: every register, including the shifters, is cleared on reset so a
  // discarded operation leaves no residue visible on sum/c_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum_sh <= w_sum_sh_next;
          r_carry  <= w_fa_c;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_sum       <= w_sum_next;
            r_c_out     <= w_fa_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH = 1, 8 and 16
// sharing one clock and reset; index 1 (WIDTH=8) carries the directed scenarios.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_v [3];
  logic        c_in_v     [3];
  logic        out_ready_v[3];
  logic [15:0] a_v        [3];
  logic [15:0] b_v        [3];
  logic        in_ready_v [3];
  logic        out_valid_v[3];
  logic        busy_v     [3];
  logic        c_out_v    [3];
  logic [15:0] sum_v      [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2, co0, co1, co2;
  logic [0:0]  s0;
  logic [7:0]  s1;
  logic [15:0] s2;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .a(a_v[0][0:0]), .b(b_v[0][0:0]), .c_in(c_in_v[0]), .out_valid(ov0),
    .out_ready(out_ready_v[0]), .sum(s0), .c_out(co0), .busy(bz0)
  );
  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .c_in(c_in_v[1]), .out_valid(ov1),
    .out_ready(out_ready_v[1]), .sum(s1), .c_out(co1), .busy(bz1)
  );
  serial_adder_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .a(a_v[2]), .b(b_v[2]), .c_in(c_in_v[2]), .out_valid(ov2),
    .out_ready(out_ready_v[2]), .sum(s2), .c_out(co2), .busy(bz2)
  );

  always_comb begin
    in_ready_v[0] = ir0;  in_ready_v[1] = ir1;  in_ready_v[2] = ir2;
    out_valid_v[0] = ov0; out_valid_v[1] = ov1; out_valid_v[2] = ov2;
    busy_v[0] = bz0;      busy_v[1] = bz1;      busy_v[2] = bz2;
    c_out_v[0] = co0;     c_out_v[1] = co1;     c_out_v[2] = co2;
    sum_v[0] = {15'b0, s0};
    sum_v[1] = {8'b0, s1};
    sum_v[2] = s2;
  end

  // Drives one operation on instance idx; returns the result, edges from accept
  // to out_valid, and ok=0 if a bounded wait expired.
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input int stall, input bit release_out,
                        output logic [15:0] s, output logic co, output int lat,
                        output bit ok);
    int guard;
    ok  = 1'b1;
    lat = 0;
    @(negedge clk);
    a_v[idx] = a; b_v[idx] = b; c_in_v[idx] = c;
    in_valid_v[idx] = 1'b1; out_ready_v[idx] = 1'b0;
    guard = 0;
    while (!in_ready_v[idx] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    a_v[idx] = ~a; b_v[idx] = ~b; c_in_v[idx] = ~c;
    while (!out_valid_v[idx] && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid_v[idx]) ok = 1'b0;
    repeat (stall) @(negedge clk);
    s  = sum_v[idx];
    co = c_out_v[idx];
    if (release_out) begin
      out_ready_v[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_v[idx] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; c_in_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({in_ready_v[i], busy_v[i], out_valid_v[i], c_out_v[i], sum_v[i]} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got in_ready=%b busy=%b out_valid=%b c_out=%b sum=%h, want 1 0 0 0 0000",
                 i, in_ready_v[i], busy_v[i], out_valid_v[i], c_out_v[i], sum_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co; int lat; bit ok;
    run_op(1, 16'h5A, 16'h3C, 1'b0, 0, 1'b1, s, co, lat, ok);
    tests_run++;
    if (!ok || lat !== 8) begin
      tests_failed++;
      $display("FAIL basic latency: got %0d edges (ok=%0b), want 8", lat, ok);
    end
    tests_run++;
    if ({co, s[7:0]} !== 9'h096) begin
      tests_failed++;
      $display("FAIL basic 5A+3C: got c_out=%b sum=%h, want 0 96", co, s[7:0]);
    end
    tests_run++;
    if (in_ready_v[1] !== 1'b1 || out_valid_v[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic return idle: got in_ready=%b out_valid=%b, want 1 0", in_ready_v[1], out_valid_v[1]);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic co; int lat; bit ok;
    run_op(1, 16'hFF, 16'h01, 1'b0, 0, 1'b1, s, co, lat, ok);
    tests_run++;
    if (!ok || {co, s[7:0]} !== 9'h100) begin
      tests_failed++;
      $display("FAIL overflow FF+01: got c_out=%b sum=%h ok=%0b, want 1 00", co, s[7:0], ok);
    end
    run_op(1, 16'hFF, 16'hFF, 1'b1, 0, 1'b1, s, co, lat, ok);
    tests_run++;
    if (!ok || {co, s[7:0]} !== 9'h1FF) begin
      tests_failed++;
      $display("FAIL overflow FF+FF+1: got c_out=%b sum=%h ok=%0b, want 1 FF", co, s[7:0], ok);
    end
  endtask

  task automatic test_hold();
    logic [15:0] s; logic co; int lat; bit ok;
    run_op(1, 16'h7F, 16'h01, 1'b1, 0, 1'b0, s, co, lat, ok);
    in_valid_v[1] = 1'b1; a_v[1] = 16'h11; b_v[1] = 16'h22; c_in_v[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (!ok || {out_valid_v[1], in_ready_v[1], c_out_v[1], sum_v[1][7:0]} !== {1'b1, 1'b0, 1'b0, 8'h81}) begin
        tests_failed++;
        $display("FAIL hold cycle %0d: got out_valid=%b in_ready=%b c_out=%b sum=%h, want 1 0 0 81",
                 k, out_valid_v[1], in_ready_v[1], c_out_v[1], sum_v[1][7:0]);
      end
    end
    out_ready_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready_v[1] !== 1'b1 || out_valid_v[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold release: got in_ready=%b out_valid=%b, want 1 0", in_ready_v[1], out_valid_v[1]);
    end
    in_valid_v[1] = 1'b0; out_ready_v[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy_v[1] !== 1'b0 || sum_v[1][7:0] !== 8'h81) begin
      tests_failed++;
      $display("FAIL hold after idle: got busy=%b sum=%h, want 0 81", busy_v[1], sum_v[1][7:0]);
    end
  endtask

  task automatic test_reset_mid_add();
    bit seen = 1'b0;
    @(negedge clk);
    a_v[1] = 16'hA5; b_v[1] = 16'h5A; c_in_v[1] = 1'b0; in_valid_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({in_ready_v[1], busy_v[1], out_valid_v[1], c_out_v[1], sum_v[1][7:0]} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset mid-add: got in_ready=%b busy=%b out_valid=%b c_out=%b sum=%h, want 1 0 0 0 00",
               in_ready_v[1], busy_v[1], out_valid_v[1], c_out_v[1], sum_v[1][7:0]);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_v[1]) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset discard: got out_valid seen=%b, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[3]  = '{8'h12, 8'h80, 8'hF0};
    logic [7:0] qb[3]  = '{8'h34, 8'h80, 8'h0F};
    logic       qc[3]  = '{1'b0, 1'b1, 1'b0};
    logic [8:0] exp[3] = '{9'h046, 9'h101, 9'h0FF};
    int acc[3];
    int cyc = 0, na = 0, nr = 0;
    bit pending = 1'b0;
    @(negedge clk);
    out_ready_v[1] = 1'b1;
    a_v[1] = {8'h0, qa[0]}; b_v[1] = {8'h0, qb[0]}; c_in_v[1] = qc[0];
    in_valid_v[1] = 1'b1;
    while (nr < 3 && cyc < 100) begin
      if (pending) begin
        na++;
        pending = 1'b0;
        if (na < 3) begin
          a_v[1] = {8'h0, qa[na]}; b_v[1] = {8'h0, qb[na]}; c_in_v[1] = qc[na];
        end else begin
          in_valid_v[1] = 1'b0;
        end
      end
      if (in_ready_v[1] && in_valid_v[1]) begin
        acc[na] = cyc;
        pending = 1'b1;
      end
      if (out_valid_v[1]) begin
        tests_run++;
        if ({c_out_v[1], sum_v[1][7:0]} !== exp[nr]) begin
          tests_failed++;
          $display("FAIL b2b result %0d: got %h, want %h", nr, {c_out_v[1], sum_v[1][7:0]}, exp[nr]);
        end
        nr++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid_v[1] = 1'b0; out_ready_v[1] = 1'b0;
    tests_run++;
    if (nr !== 3 || na !== 3) begin
      tests_failed++;
      $display("FAIL b2b count: got %0d results %0d accepts, want 3 3", nr, na);
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (acc[i] - acc[i-1] !== 10) begin
          tests_failed++;
          $display("FAIL b2b spacing %0d: got %0d cycles, want 10", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random(input int idx, input int w);
    logic [15:0] mask = 16'((17'(1) << w) - 1);
    logic [15:0] ra, rb, s;
    logic rc, co;
    logic [16:0] exp, got;
    int lat; bit ok;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom) & mask;
      rb = 16'($urandom) & mask;
      rc = 1'($urandom);
      run_op(idx, ra, rb, rc, int'($urandom_range(0, 2)), 1'b1, s, co, lat, ok);
      exp = 17'(ra) + 17'(rb) + 17'(rc);
      got = (17'(co) << w) | 17'(s & mask);
      tests_run++;
      if (!ok || lat !== w || got !== exp) begin
        tests_failed++;
        $display("FAIL random w=%0d #%0d: a=%h b=%h c=%b got %h lat %0d ok %0b, want %h lat %0d",
                 w, n, ra, rb, rc, got, lat, ok, exp, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_hold();
    test_reset_mid_add();
    test_back_to_back();
    test_random(0, 1);
    test_random(1, 8);
    test_random(2, 16);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
